matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_addr_gen.sv | 38 +++
 rtl/matrix_loader.sv | 138 +++++++++++++
 tb/tb_matrix_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the matrix loader block.
package matrix_pkg;

  localparam int DATA_W = 32;
  localparam int DIM_W  = 8;
  localparam int MAX_M  = 16;
  localparam int MAX_N  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Row/column walker for the matrix loader; c advances first and wraps into r.
module matrix_addr_gen #(
  parameter int DIM_W = matrix_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  input  logic             step,
  input  logic             clear,
  output logic [DIM_W-1:0] r,
  output logic [DIM_W-1:0] c,
  output logic             last
);
  import matrix_pkg::*;

  logic r_last;
  logic c_last;

  assign c_last = (c == n - 1'b1);
  assign r_last = (r == m - 1'b1);
  assign last   = r_last && c_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r <= '0;
      c <= '0;
    end else if (step) begin
      if (c_last) begin
        c <= '0;
        r <= r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams a flat row-major matrix into an addressed write port, one entry per accepted cycle.
// Define MATRIX_LOADER_TRANSPOSE_EN to honour the transpose input (swapped write addresses).
module matrix_loader #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int MAX_M  = matrix_pkg::MAX_M,
  parameter int MAX_N  = matrix_pkg::MAX_N,
  parameter int DIM_W  = matrix_pkg::DIM_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DIM_W-1:0]                m_dim,
  input  logic [DIM_W-1:0]                n_dim,
  input  logic                            transpose,
  input  logic [MAX_M*MAX_N*DATA_W-1:0]   matrix_in,
  input  logic                            wr_ready,
  output logic                            wr_en,
  output logic [DIM_W-1:0]                wr_m_addr,
  output logic [DIM_W-1:0]                wr_n_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  import matrix_pkg::*;

  localparam int ENTRIES = MAX_M * MAX_N;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  state_t             state;
  state_t             state_next;
  logic [DIM_W-1:0]   m_lat;
  logic [DIM_W-1:0]   n_lat;
  logic               tr_lat;
  logic [DIM_W-1:0]   r;
  logic [DIM_W-1:0]   c;
  logic               last;
  logic               dims_ok;
  logic               accept;
  logic               step;
  logic               err_next;
  logic [2*DIM_W-1:0] k;
  logic [DATA_W-1:0]  entries [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entries
    assign entries[i] = matrix_in[i*DATA_W +: DATA_W];
  end

  assign dims_ok = (m_dim != '0) && (n_dim != '0) &&
                   (32'(m_dim) <= 32'(MAX_M)) && (32'(n_dim) <= 32'(MAX_N));
  assign accept  = (state == IDLE) && start && dims_ok;
  assign step    = (state == LOAD) && wr_ready;
  assign k       = {{DIM_W{1'b0}}, r} * {{DIM_W{1'b0}}, n_lat} + {{DIM_W{1'b0}}, c};

`ifndef MATRIX_LOADER_TRANSPOSE_EN
  logic unused_transpose;
  assign unused_transpose = transpose;
`endif

  matrix_addr_gen #(.DIM_W(DIM_W)) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .m     (m_lat),
    .n     (n_lat),
    .step  (step),
    .clear (accept),
    .r     (r),
    .c     (c),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      m_lat  <= '0;
      n_lat  <= '0;
      tr_lat <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (accept) begin
        m_lat <= m_dim;
        n_lat <= n_dim;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        tr_lat <= transpose;
`else
        tr_lat <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (dims_ok) state_next = LOAD;
          else         err_next   = 1'b1;
        end
      end
      LOAD: begin
        if (wr_ready && last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port is driven straight from registered state, so a stalled write holds by construction.
  always_comb begin
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr_m_addr = '0;
    wr_n_addr = '0;
    wr_data   = '0;
    case (state)
      LOAD: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (k < (2*DIM_W)'(ENTRIES)) wr_data = entries[k[IDX_W-1:0]];
        if (tr_lat) begin
          wr_m_addr = c;
          wr_n_addr = r;
        end else begin
          wr_m_addr = r;
          wr_n_addr = c;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: a row/column reference model queues expected events, a monitor pops them.
module tb_matrix_loader;

  localparam int DATA_W = 32;
  localparam int MAX_M  = 16;
  localparam int MAX_N  = 16;
  localparam int DIM_W  = 8;
  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int                kind;
    logic [DIM_W-1:0]  ma;
    logic [DIM_W-1:0]  na;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic                          start = 1'b0;
  logic [DIM_W-1:0]              m_dim = '0;
  logic [DIM_W-1:0]              n_dim = '0;
  logic                          transpose = 1'b0;
  logic [MAX_M*MAX_N*DATA_W-1:0] matrix_in = '0;
  logic                          wr_ready = 1'b0;
  logic                          wr_en;
  logic [DIM_W-1:0]              wr_m_addr;
  logic [DIM_W-1:0]              wr_n_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          busy;
  logic                          done;
  logic                          err;

  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];

  matrix_loader #(.DATA_W(DATA_W), .MAX_M(MAX_M), .MAX_N(MAX_N), .DIM_W(DIM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m_dim     (m_dim),
    .n_dim     (n_dim),
    .transpose (transpose),
    .matrix_in (matrix_in),
    .wr_ready  (wr_ready),
    .wr_en     (wr_en),
    .wr_m_addr (wr_m_addr),
    .wr_n_addr (wr_n_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Monitor: every DUT-visible event must match the head of the model queue.
  always @(negedge clk) begin
    int fk;
    if (!reset) begin
      fk = (exp_q.size() != 0) ? exp_q[0].kind : -1;
      if (wr_en) begin
        checkOutput("write_order", 64'(fk), 64'(K_WR));
        if (fk == K_WR) begin
          checkOutput("wr_m_addr", 64'(wr_m_addr), 64'(exp_q[0].ma));
          checkOutput("wr_n_addr", 64'(wr_n_addr), 64'(exp_q[0].na));
          checkOutput("wr_data", 64'(wr_data), 64'(exp_q[0].data));
          if (wr_ready) void'(exp_q.pop_front());
        end
      end else begin
        checkOutput("idle_outputs", 64'({wr_m_addr, wr_n_addr, wr_data}), 64'(0));
      end
      fk = (exp_q.size() != 0) ? exp_q[0].kind : -1;
      if (done) begin
        checkOutput("done_order", 64'(fk), 64'(K_DONE));
        if (fk == K_DONE) void'(exp_q.pop_front());
      end
      fk = (exp_q.size() != 0) ? exp_q[0].kind : -1;
      if (err) begin
        checkOutput("err_order", 64'(fk), 64'(K_ERR));
        if (fk == K_ERR) void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: fill the source and queue m*n writes in row-major order, then done.
  task automatic loadMatrix(input int m, input int n, input bit tr, input bit ramp);
    exp_t e;
    bit   tr_eff;
    for (int k = 0; k < MAX_M * MAX_N; k++) begin
      if (ramp) matrix_in[k*DATA_W +: DATA_W] = DATA_W'(32'h10 + k);
      else      matrix_in[k*DATA_W +: DATA_W] = $urandom();
    end
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    tr_eff = tr;
`else
    tr_eff = 1'b0;
`endif
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        e.kind = K_WR;
        e.ma   = tr_eff ? DIM_W'(c) : DIM_W'(r);
        e.na   = tr_eff ? DIM_W'(r) : DIM_W'(c);
        e.data = matrix_in[(r*n + c)*DATA_W +: DATA_W];
        exp_q.push_back(e);
      end
    end
    e.kind = K_DONE;
    e.ma   = '0;
    e.na   = '0;
    e.data = '0;
    exp_q.push_back(e);
    m_dim     = DIM_W'(m);
    n_dim     = DIM_W'(n);
    transpose = tr;
  endtask

  task automatic applyStimulus(input int m, input int n, input bit tr, input bit ramp,
                               input bit rnd, input bit exact);
    int cycles;
    loadMatrix(m, n, tr, ramp);
    rand_ready = rnd;
    if (rnd) wr_ready = ($urandom_range(0, 3) != 0);
    else     wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("first_wr_en", 64'(wr_en), 64'(1));
    checkOutput("busy_load", 64'(busy), 64'(1));
    cycles = 0;
    while (!done && cycles < m*n*20 + 50) begin
      tick();
      cycles++;
    end
    checkOutput("done_seen", 64'(done), 64'(1));
    if (exact) checkOutput("done_latency", 64'(cycles), 64'(m*n));
    checkOutput("busy_done", 64'(busy), 64'(0));
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    tick();
    checkOutput("done_width", 64'(done), 64'(0));
    checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic applyErr(input int m, input int n);
    exp_t e;
    e.kind = K_ERR;
    e.ma   = '0;
    e.na   = '0;
    e.data = '0;
    exp_q.push_back(e);
    m_dim = DIM_W'(m);
    n_dim = DIM_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_pulse", 64'(err), 64'(1));
    checkOutput("err_busy", 64'(busy), 64'(0));
    tick();
    checkOutput("err_clear", 64'(err), 64'(0));
    checkOutput("err_busy_after", 64'(busy), 64'(0));
    checkOutput("err_queue", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic applyStall();
    int cycles;
    loadMatrix(2, 2, 1'b0, 1'b0);
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_en", 64'(wr_en), 64'(1));
      checkOutput("stall_hold_addr", 64'({wr_m_addr, wr_n_addr}), 64'({DIM_W'(0), DIM_W'(1)}));
    end
    wr_ready = 1'b1;
    cycles = 0;
    while (!done && cycles < 50) begin
      tick();
      cycles++;
    end
    checkOutput("stall_done_latency", 64'(cycles), 64'(3));
    tick();
    checkOutput("stall_queue", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic applyAbort();
    loadMatrix(4, 4, 1'b0, 1'b0);
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_ctrl", 64'({wr_en, busy, done, err}), 64'(0));
    checkOutput("abort_data", 64'({wr_m_addr, wr_n_addr, wr_data}), 64'(0));
    exp_q.delete();
    reset = 1'b0;
    applyStimulus(1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic applyRestart();
    int done_count;
    loadMatrix(3, 3, 1'b0, 1'b0);
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    start      = 1'b1;
    tick();
    done_count = 0;
    for (int i = 0; i < 13; i++) begin
      if (i >= 10)          start = 1'b0;
      else if (i % 2 == 0)  start = 1'b1;
      else                  start = 1'($urandom_range(0, 1));
      tick();
      if (done) done_count++;
    end
    start = 1'b0;
    checkOutput("restart_single_done", 64'(done_count), 64'(1));
    checkOutput("restart_queue", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("reset_ctrl", 64'({wr_en, busy, done, err}), 64'(0));
    checkOutput("reset_data", 64'({wr_m_addr, wr_n_addr, wr_data}), 64'(0));
    reset = 1'b0;

    applyStimulus(2, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(2, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStall();
    applyErr(0, 3);
    applyErr(2, MAX_N + 1);
    applyAbort();
    applyRestart();
    applyStimulus(1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(MAX_M, MAX_N, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(1, MAX_M), $urandom_range(1, MAX_N),
                    1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    end
    applyErr(MAX_M + 1, 1);
    applyErr(3, 0);

    repeat (3) tick();
    checkOutput("final_queue", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
